// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control and register block: sequences fetch, execute, data read and data write around an external ALU.
// One request (instruction or data) is outstanding at a time; every wait on instr_valid or mem_ack stalls the sequence.
module hack_cpu_ctrl #(
    parameter int PC_W = 15,
    parameter int AW   = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            instr_req,
    output logic [PC_W-1:0] instr_addr,
    input  logic            instr_valid,
    input  logic [15:0]     instr,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [AW-1:0]   mem_addr,
    output logic [15:0]     mem_wdata,
    input  logic [15:0]     mem_rdata,
    input  logic            mem_ack,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    output logic [5:0]      alu_ctl,
    input  logic [15:0]     alu_out,
    input  logic            alu_zr,
    input  logic            alu_ng,
    output logic [PC_W-1:0] pc
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] MRD   = 2'd2;
    localparam logic [1:0] MWR   = 2'd3;

    logic [1:0]      state;
    logic [15:0]     a_reg;
    logic [15:0]     d_reg;
    logic [15:0]     ir;
    logic [15:0]     m_reg;
    logic [15:0]     wdata;
    logic [AW-1:0]   waddr;
    logic [PC_W-1:0] pc_reg;
    logic            m_loaded;
    logic            jump;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc_reg + PC_W'(1);

    always_comb begin
        jump = 1'b0;
        case (ir[2:0])
            3'b000: jump = 1'b0;
            3'b001: jump = !alu_zr && !alu_ng;
            3'b010: jump = alu_zr;
            3'b011: jump = !alu_ng;
            3'b100: jump = alu_ng;
            3'b101: jump = !alu_zr;
            3'b110: jump = alu_zr || alu_ng;
            3'b111: jump = 1'b1;
            default: jump = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            a_reg    <= '0;
            d_reg    <= '0;
            ir       <= '0;
            m_reg    <= '0;
            wdata    <= '0;
            waddr    <= '0;
            pc_reg   <= '0;
            m_loaded <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!ir[15]) begin
                        a_reg  <= {1'b0, ir[14:0]};
                        pc_reg <= pc_inc;
                        state  <= FETCH;
                    end else if (ir[12] && !m_loaded) begin
                        state <= MRD;
                    end else begin
                        // a_reg on the right-hand side is still the pre-instruction A
                        if (ir[5]) a_reg <= alu_out;
                        if (ir[4]) d_reg <= alu_out;
                        if (ir[3]) begin
                            waddr <= a_reg[AW-1:0];
                            wdata <= alu_out;
                        end
                        pc_reg   <= jump ? a_reg[PC_W-1:0] : pc_inc;
                        m_loaded <= 1'b0;
                        state    <= ir[3] ? MWR : FETCH;
                    end
                end
                MRD: begin
                    if (mem_ack) begin
                        m_reg    <= mem_rdata;
                        m_loaded <= 1'b1;
                        state    <= EXEC;
                    end
                end
                MWR: begin
                    if (mem_ack) state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    // instr_req is gated by rst_n so it drops while reset is held
    assign instr_req  = rst_n && (state == FETCH);
    assign instr_addr = pc_reg;
    assign mem_rd     = (state == MRD);
    assign mem_wr     = (state == MWR);
    assign mem_addr   = (state == MWR) ? waddr : a_reg[AW-1:0];
    assign mem_wdata  = wdata;
    assign alu_x      = d_reg;
    assign alu_y      = ir[12] ? m_reg : a_reg;
    assign alu_ctl    = ir[11:6];
    assign pc         = pc_reg;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: behavioural Hack ALU plus instruction-level CPU model, directed then random programs.
module tb_hack_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req;
    logic [14:0] instr_addr;
    logic        instr_valid;
    logic [15:0] instr;
    logic        mem_rd, mem_wr;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [15:0] alu_x, alu_y;
    logic [5:0]  alu_ctl;
    logic [15:0] alu_out;
    logic        alu_zr, alu_ng;
    logic [14:0] pc;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_a, m_d, m_m;
    logic [14:0] m_pc;
    logic        m_ir12;

    hack_cpu_ctrl #(.PC_W(15), .AW(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_valid(instr_valid), .instr(instr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_x(alu_x), .alu_y(alu_y), .alu_ctl(alu_ctl),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .pc(pc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0 : x;
        if (c[4]) xx = ~xx;
        yy = c[3] ? 16'h0 : y;
        if (c[2]) yy = ~yy;
        o = c[1] ? (xx + yy) : (xx & yy);
        if (c[0]) o = ~o;
        return o;
    endfunction

    assign alu_out = hack_alu(alu_x, alu_y, alu_ctl);
    assign alu_zr  = (alu_out == 16'h0);
    assign alu_ng  = alu_out[15];

    function automatic bit jump_taken(input logic [15:0] r, input logic [2:0] j);
        logic signed [15:0] v;
        v = r;
        return (j[2] && (v < 0)) || (j[1] && (v == 0)) || (j[0] && (v > 0));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 16'h0; m_d = 16'h0; m_m = 16'h0; m_pc = 15'h0; m_ir12 = 1'b0;
    endtask

    task automatic fetch_site();
        int n = 0;
        while (!instr_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("instr_req", instr_req, 1);
        chk("pc", pc, m_pc);
        chk("instr_addr", instr_addr, m_pc);
        chk("mem_idle", {mem_rd, mem_wr}, 2'b00);
        chk("reg_d", alu_x, m_d);
        chk("reg_a_or_m", alu_y, m_ir12 ? m_m : m_a);
    endtask

    task automatic fetch(input logic [15:0] w, input int iw);
        fetch_site();
        repeat (iw) begin
            instr = 16'($urandom);
            instr_valid = 1'b0;
            @(negedge clk);
            chk("ireq_hold", instr_req, 1);
        end
        instr = w;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 16'($urandom);
    endtask

    task automatic mem_read(input logic [15:0] rd, input int mw);
        int n = 0;
        while (!mem_rd && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rd_req", mem_rd, 1);
        chk("rd_excl", mem_wr, 0);
        chk("rd_addr", mem_addr, m_a[14:0]);
        repeat (mw) begin
            @(negedge clk);
            chk("rd_hold", mem_rd, 1);
            chk("rd_addr_hold", mem_addr, m_a[14:0]);
        end
        mem_rdata = rd;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
    endtask

    task automatic mem_write(input logic [14:0] addr, input logic [15:0] data, input int mw);
        int n = 0;
        while (!mem_wr && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wr_req", mem_wr, 1);
        chk("wr_excl", mem_rd, 0);
        chk("wr_addr", mem_addr, addr);
        chk("wr_data", mem_wdata, data);
        repeat (mw) begin
            @(negedge clk);
            chk("wr_hold", mem_wr, 1);
            chk("wr_addr_hold", mem_addr, addr);
            chk("wr_data_hold", mem_wdata, data);
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic run_instr(input logic [15:0] w, input int iw, input int mw, input logic [15:0] rd);
        logic [15:0] y, res, old_a;
        fetch(w, iw);
        if (!w[15]) begin
            m_a  = {1'b0, w[14:0]};
            m_pc = m_pc + 15'd1;
        end else begin
            if (w[12]) begin
                mem_read(rd, mw);
                m_m = rd;
                y = m_m;
            end else begin
                y = m_a;
            end
            chk("alu_ctl", alu_ctl, w[11:6]);
            chk("alu_x", alu_x, m_d);
            chk("alu_y", alu_y, y);
            res   = hack_alu(m_d, y, w[11:6]);
            old_a = m_a;
            if (w[5]) m_a = res;
            if (w[4]) m_d = res;
            m_pc = jump_taken(res, w[2:0]) ? old_a[14:0] : m_pc + 15'd1;
            if (w[3]) mem_write(old_a[14:0], res, mw);
        end
        m_ir12 = w[12];
    endtask

    initial begin
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = 16'h0;
        mem_ack = 1'b0;
        mem_rdata = 16'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_ireq", instr_req, 0);
        chk("rst_mem", {mem_rd, mem_wr}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_d", alu_x, 0);
        chk("rst_y", alu_y, 0);
        chk("rst_ctl", alu_ctl, 0);

        // @5 at PC 0, zero-wait: request back in cycle 3
        run_instr(16'h0005, 0, 0, 16'h0);
        chk("t1_exec_ireq", instr_req, 0);
        @(negedge clk);
        chk("t1_c3_ireq", instr_req, 1);
        chk("t1_pc", pc, 1);
        chk("t1_y", alu_y, 16'h0005);
        chk("t1_d", alu_x, 0);

        run_instr(16'hEC10, 0, 0, 16'h0);            // D=A
        run_instr(16'h0003, 0, 0, 16'h0);
        run_instr(16'hEC10, 1, 0, 16'h0);            // D=3
        run_instr(16'h0010, 0, 0, 16'h0);
        run_instr(16'hE7C8, 0, 3, 16'h0);            // M=D+1, ack after 3 waits

        run_instr(16'h0005, 0, 0, 16'h0);
        run_instr(16'hEC10, 0, 0, 16'h0);
        run_instr(16'h0020, 0, 0, 16'h0);
        run_instr(16'hE301, 0, 0, 16'h0);            // D;JGT with D=5
        run_instr(16'hEA90, 0, 0, 16'h0);            // D=0
        run_instr(16'h0020, 0, 0, 16'h0);
        run_instr(16'hE301, 0, 0, 16'h0);
        run_instr(16'h7FFF, 0, 0, 16'h0);
        run_instr(16'hEC10, 0, 0, 16'h0);
        run_instr(16'hE7D0, 0, 0, 16'h0);            // D=D+1 -> 0x8000
        run_instr(16'h0020, 0, 0, 16'h0);
        run_instr(16'hE301, 2, 0, 16'h0);

        run_instr(16'h0100, 0, 0, 16'h0);
        run_instr(16'hFCA8, 0, 1, 16'h0007);         // AM=M-1

        run_instr(16'h7FFF, 0, 0, 16'h0);
        run_instr(16'hEA87, 0, 0, 16'h0);            // 0;JMP to 0x7FFF
        run_instr(16'h0001, 0, 0, 16'h0);            // PC wraps to 0
        fetch_site();
        chk("wrap_pc", pc, 0);

        for (int i = 0; i < 60; i++) begin
            run_instr(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 16'($urandom));
        end

        // reset while a write is pending
        run_instr(16'h0033, 0, 0, 16'h0);
        fetch(16'hE7C8, 0);
        begin
            int n = 0;
            while (!mem_wr && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("pre_rst_wr", mem_wr, 1);
        rst_n = 1'b0;
        #1;
        chk("async_wr_drop", mem_wr, 0);
        chk("async_ireq", instr_req, 0);
        chk("async_pc", pc, 0);
        chk("async_d", alu_x, 0);
        chk("async_a", alu_y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_instr(16'h0042, 1, 0, 16'h0);
        run_instr(16'hEC10, 0, 0, 16'h0);
        fetch_site();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
